// File: rtl/blit_pkg.sv
// Shared types and defaults for the blitter command-list DMA sequencer.
package blit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_REQ   = 3'd2,
    ST_RECV  = 3'd3,
    ST_DRAIN = 3'd4
  } blit_state_e;

  localparam int DEF_BURST_WORDS  = 16;
  localparam int DEF_BUF_DEPTH    = 32;
  localparam int DEF_SLOT_RESERVE = 4;

  // Useful words in the next burst: whatever is left, capped at one burst.
  function automatic logic [15:0] burst_useful(input logic [15:0] remaining,
                                               input logic [15:0] burst);
    return (remaining < burst) ? remaining : burst;
  endfunction

endpackage

// File: rtl/blit_cmd_buffer.sv
// Prefetch FIFO for command words: circular buffer with one extra pointer bit
// so full and empty are distinguishable. Read data is first-word fall-through.
module blit_cmd_buffer #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             empty
);

  localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
  localparam logic [AW:0] PTR_ZERO = (AW + 1)'(0);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (count == PTR_ZERO);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update: flush empties the buffer and overrides any write/read.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_en && !empty) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clock) begin
    if (wr_en && !flush) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/blit_cmd_dma.sv
// Command-list DMA sequencer: bursts a list of blit command words out of SDRAM
// into a prefetch buffer and trickles them into the blitter command FIFO,
// yielding to direct CPU command writes.
module blit_cmd_dma
  import blit_pkg::*;
#(
  parameter int BURST_WORDS  = DEF_BURST_WORDS,
  parameter int BUF_DEPTH    = DEF_BUF_DEPTH,
  parameter int SLOT_RESERVE = DEF_SLOT_RESERVE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_blit_valid,
  input  logic [31:0] cpu_blit_command,
  input  logic        cpu_blit_privaledge,
  input  logic        dma_start,
  input  logic [25:0] dma_addr,
  input  logic [15:0] dma_count,
  input  logic        dma_privaledge,
  input  logic        dma_abort,
  output logic        dma_busy,
  output logic        dma_done,
  output logic        dma_aborted,
  input  logic [9:0]  blit_fifo_slots_free,
  output logic        hwregs_blit_valid,
  output logic [31:0] hwregs_blit_command,
  output logic        hwregs_blit_privaledge,
  output logic        sdram_request,
  output logic [25:0] sdram_address,
  input  logic        sdram_ready,
  input  logic        sdram_rvalid,
  input  logic [31:0] sdram_rdata,
  input  logic [25:0] sdram_raddress,
  input  logic        sdram_complete
);

  localparam int          AW         = $clog2(BUF_DEPTH);
  localparam logic [15:0] BURST_W16  = 16'(BURST_WORDS);
  localparam logic [AW:0] BURST_WC   = (AW + 1)'(BURST_WORDS);
  localparam logic [AW:0] DEPTH_WC   = (AW + 1)'(BUF_DEPTH);
  localparam logic [25:0] ADDR_STEP  = 26'(4 * BURST_WORDS);
  localparam logic [25:0] ADDR_ALIGN = 26'h3FF_FFFC;
  localparam logic [9:0]  RESERVE10  = 10'(SLOT_RESERVE);

  blit_state_e state_q, state_d;
  logic [25:0] cur_addr_q, cur_addr_d;
  logic [25:0] burst_addr_q, burst_addr_d;
  logic [15:0] count_q, count_d;
  logic [15:0] words_req_q, words_req_d;
  logic [15:0] useful_q, useful_d;
  logic        priv_q, priv_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;
  logic        abort_pend_q, abort_pend_d;
  logic        issued_q, issued_d;
  logic        request_q, request_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_cmd_q, out_cmd_d;
  logic        out_priv_q, out_priv_d;

  logic        buf_wr, buf_flush, buf_empty, dma_sel;
  logic [31:0] buf_rd_data;
  logic [AW:0] buf_count, buf_free;
  logic [15:0] remaining, useful_calc;
  logic [25:0] beat_off;
  logic        abort_imm, abort_fin, abort_now;

  blit_cmd_buffer #(.DEPTH(BUF_DEPTH), .WIDTH(32)) u_buf (
    .clock   (clock),
    .reset   (reset),
    .flush   (buf_flush),
    .wr_en   (buf_wr),
    .wr_data (sdram_rdata),
    .rd_en   (dma_sel),
    .rd_data (buf_rd_data),
    .count   (buf_count),
    .empty   (buf_empty)
  );

  assign buf_free    = DEPTH_WC - buf_count;
  assign remaining   = count_q - words_req_q;
  assign useful_calc = burst_useful(remaining, BURST_W16);
  // Beat position inside the current burst, taken from the returned address.
  assign beat_off    = sdram_raddress - burst_addr_q;

  // Immediate aborts happen where no burst is in flight; an abort that lands
  // in RECV (or with ready) is held until the arbiter finishes the burst.
  assign abort_imm = dma_abort && ((state_q == ST_CHECK) || (state_q == ST_DRAIN) ||
                                   ((state_q == ST_REQ) && !sdram_ready));
  assign abort_fin = (state_q == ST_RECV) && sdram_complete && (abort_pend_q || dma_abort);
  assign abort_now = abort_imm || abort_fin;

  assign dma_busy               = busy_q;
  assign dma_done               = done_q;
  assign dma_aborted            = aborted_q;
  assign hwregs_blit_valid      = out_valid_q;
  assign hwregs_blit_command    = out_cmd_q;
  assign hwregs_blit_privaledge = out_priv_q;
  assign sdram_request          = request_q;
  assign sdram_address          = cur_addr_q;

  // State register and all sequencer/output flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cur_addr_q   <= 26'd0;
      burst_addr_q <= 26'd0;
      count_q      <= 16'd0;
      words_req_q  <= 16'd0;
      useful_q     <= 16'd0;
      priv_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      issued_q     <= 1'b0;
      request_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_cmd_q    <= 32'd0;
      out_priv_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      burst_addr_q <= burst_addr_d;
      count_q      <= count_d;
      words_req_q  <= words_req_d;
      useful_q     <= useful_d;
      priv_q       <= priv_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      abort_pend_q <= abort_pend_d;
      issued_q     <= issued_d;
      request_q    <= request_d;
      out_valid_q  <= out_valid_d;
      out_cmd_q    <= out_cmd_d;
      out_priv_q   <= out_priv_d;
    end
  end

  // Fetch sequencer: next state, list bookkeeping and buffer write/flush.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    burst_addr_d = burst_addr_q;
    count_d      = count_q;
    words_req_d  = words_req_q;
    useful_d     = useful_q;
    priv_d       = priv_q;
    busy_d       = busy_q;
    aborted_d    = aborted_q;
    abort_pend_d = abort_pend_q;
    done_d       = 1'b0;
    buf_wr       = 1'b0;
    buf_flush    = 1'b0;
    if (abort_now) begin
      buf_flush    = 1'b1;
      aborted_d    = 1'b1;
      done_d       = 1'b1;
      busy_d       = 1'b0;
      abort_pend_d = 1'b0;
      state_d      = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dma_start) begin
            cur_addr_d   = dma_addr & ADDR_ALIGN;
            count_d      = dma_count;
            priv_d       = dma_privaledge;
            words_req_d  = 16'd0;
            aborted_d    = 1'b0;
            abort_pend_d = 1'b0;
            if (dma_count == 16'd0) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end else begin
              busy_d  = 1'b1;
              state_d = ST_CHECK;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (words_req_q == count_q) begin
            state_d = ST_DRAIN;
          end else if (buf_free >= BURST_WC) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_CHECK;
          end
        end
        ST_REQ: begin
          if (sdram_ready) begin
            burst_addr_d = cur_addr_q;
            cur_addr_d   = cur_addr_q + ADDR_STEP;
            useful_d     = useful_calc;
            words_req_d  = words_req_q + useful_calc;
            abort_pend_d = dma_abort;
            state_d      = ST_RECV;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_RECV: begin
          // Surplus beats past the list end, and any beat after an abort, are dropped.
          if (sdram_rvalid && !abort_pend_q && !dma_abort &&
              (beat_off < {8'd0, useful_q, 2'b00})) begin
            buf_wr = 1'b1;
          end else begin
            buf_wr = 1'b0;
          end
          if (dma_abort) begin
            abort_pend_d = 1'b1;
          end else begin
            abort_pend_d = abort_pend_q;
          end
          if (sdram_complete) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_RECV;
          end
        end
        ST_DRAIN: begin
          if (buf_empty) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    request_d = (state_d == ST_REQ);
  end

  // Output stage: CPU words win; DMA words go at most every other cycle and
  // only while the blitter reports headroom beyond the reserve.
  always_comb begin
    if (!cpu_blit_valid && !buf_empty && (blit_fifo_slots_free > RESERVE10) &&
        !issued_q && !dma_abort && !abort_pend_q) begin
      dma_sel = 1'b1;
    end else begin
      dma_sel = 1'b0;
    end
    issued_d = dma_sel;
    if (cpu_blit_valid) begin
      out_valid_d = 1'b1;
      out_cmd_d   = cpu_blit_command;
      out_priv_d  = cpu_blit_privaledge;
    end else if (dma_sel) begin
      out_valid_d = 1'b1;
      out_cmd_d   = buf_rd_data;
      out_priv_d  = priv_q;
    end else begin
      out_valid_d = 1'b0;
      out_cmd_d   = 32'd0;
      out_priv_d  = 1'b0;
    end
  end

endmodule

// File: tb/tb_blit_cmd_dma.sv
// Self-checking bench for blit_cmd_dma: table of list scenarios, randomized
// lists, and hand sequences for zero-length lists and reset during a request.
module tb_blit_cmd_dma;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_blit_valid = 1'b0;
  logic [31:0] cpu_blit_command = 32'd0;
  logic        cpu_blit_privaledge = 1'b0;
  logic        dma_start = 1'b0;
  logic [25:0] dma_addr = 26'd0;
  logic [15:0] dma_count = 16'd0;
  logic        dma_privaledge = 1'b0;
  logic        dma_abort = 1'b0;
  logic        dma_busy, dma_done, dma_aborted;
  logic [9:0]  blit_fifo_slots_free = 10'd512;
  logic        hwregs_blit_valid;
  logic [31:0] hwregs_blit_command;
  logic        hwregs_blit_privaledge;
  logic        sdram_request;
  logic [25:0] sdram_address;
  logic        sdram_ready = 1'b0;
  logic        sdram_rvalid = 1'b0;
  logic [31:0] sdram_rdata = 32'd0;
  logic [25:0] sdram_raddress = 26'd0;
  logic        sdram_complete = 1'b0;

  blit_cmd_dma dut (
    .clock(clock), .reset(reset),
    .cpu_blit_valid(cpu_blit_valid), .cpu_blit_command(cpu_blit_command),
    .cpu_blit_privaledge(cpu_blit_privaledge),
    .dma_start(dma_start), .dma_addr(dma_addr), .dma_count(dma_count),
    .dma_privaledge(dma_privaledge), .dma_abort(dma_abort),
    .dma_busy(dma_busy), .dma_done(dma_done), .dma_aborted(dma_aborted),
    .blit_fifo_slots_free(blit_fifo_slots_free),
    .hwregs_blit_valid(hwregs_blit_valid), .hwregs_blit_command(hwregs_blit_command),
    .hwregs_blit_privaledge(hwregs_blit_privaledge),
    .sdram_request(sdram_request), .sdram_address(sdram_address),
    .sdram_ready(sdram_ready), .sdram_rvalid(sdram_rvalid), .sdram_rdata(sdram_rdata),
    .sdram_raddress(sdram_raddress), .sdram_complete(sdram_complete)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] cnt;
    logic [25:0] addr;
    logic        priv;
    int          slots_mode;  // 0: 512, 1: random 0..20, 2: 4 then 100 from cycle 150
    int          cpu_n;       // >0: CPU burst of n writes at cycle 20, <0: random writes
    int          abort_spec;  // 0: none, >0: at that cycle if busy, <0: 2 cycles after -n'th request
    int          exp_reqs;
  } vec_t;

  int vec_cnt = 0;
  int miss_cnt = 0;

  logic [32:0] exp_dma[$];
  logic [25:0] exp_req[$];
  int dma_seen, req_seen, done_seen;
  bit blocked, prev_dma, busy_prev;
  bit in_burst, ready_drv, req_prev, hold_ready;
  logic [25:0] addr_prev, burst_base;
  int beat;

  function automatic logic [31:0] mem_word(input logic [25:0] a);
    return 32'h5A00_0000 ^ {6'd0, a} ^ {a[15:0], 16'd0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [32:0] e;
    if (reset) begin
      exp_dma.delete(); exp_req.delete();
      prev_dma = 1'b0; busy_prev = 1'b0;
      return;
    end
    if (dma_abort && busy_prev) begin
      blocked = 1'b1;
      exp_dma.delete();
    end
    if (cpu_blit_valid) begin
      check("cpu_fwd", 64'({hwregs_blit_valid, hwregs_blit_privaledge, hwregs_blit_command}),
            64'({1'b1, cpu_blit_privaledge, cpu_blit_command}));
      prev_dma = 1'b0;
    end else if (hwregs_blit_valid) begin
      if (exp_dma.size() == 0) begin
        vec_cnt++; miss_cnt++;
        $display("FAIL dma_unexpected: got word %h, expected no DMA word", hwregs_blit_command);
      end else begin
        e = exp_dma.pop_front();
        check("dma_word", 64'({hwregs_blit_privaledge, hwregs_blit_command}), 64'(e));
        dma_seen++;
      end
      check("dma_spacing", 64'(prev_dma), 64'd0);
      check("dma_slots", 64'(blit_fifo_slots_free > 10'd4), 64'd1);
      prev_dma = 1'b1;
    end else begin
      prev_dma = 1'b0;
    end
    if (dma_done) begin
      done_seen++;
      check("done_after_burst", 64'(in_burst), 64'd0);
    end
    busy_prev = dma_busy;
  endtask

  // Behavioural arbiter: random ready latency, random beat gaps, 16-beat bursts.
  task automatic sdram_step();
    logic [25:0] ba;
    if (reset) begin
      in_burst = 1'b0; ready_drv = 1'b0;
      sdram_ready = 1'b0; sdram_rvalid = 1'b0; sdram_complete = 1'b0;
      req_prev = 1'b0;
      return;
    end
    if (ready_drv && req_prev) begin
      req_seen++;
      if (exp_req.size() == 0) begin
        vec_cnt++; miss_cnt++;
        $display("FAIL req_unexpected: got request at %h, expected none", addr_prev);
      end else begin
        check("req_addr", 64'(addr_prev), 64'(exp_req.pop_front()));
      end
      burst_base = addr_prev; beat = 0; in_burst = 1'b1;
    end
    ready_drv = 1'b0; sdram_rvalid = 1'b0; sdram_complete = 1'b0;
    if (in_burst) begin
      if (beat < 16) begin
        if ($urandom_range(0, 3) != 0) begin
          ba = burst_base + 26'(4 * beat);
          sdram_rvalid = 1'b1; sdram_rdata = mem_word(ba); sdram_raddress = ba;
          beat++;
          if (beat == 16 && $urandom_range(0, 1) == 1) begin
            sdram_complete = 1'b1; in_burst = 1'b0;
          end
        end
      end else begin
        sdram_complete = 1'b1; in_burst = 1'b0;
      end
    end else if (sdram_request && !hold_ready) begin
      ready_drv = ($urandom_range(0, 2) != 0);
    end
    sdram_ready = ready_drv;
    req_prev = sdram_request;
    addr_prev = sdram_address;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    monitor();
    sdram_step();
  endtask

  task automatic run_list(input vec_t v);
    logic [25:0] base;
    int abort_cyc, after;
    bit fired;
    base = v.addr & 26'h3FF_FFFC;
    exp_dma.delete(); exp_req.delete();
    for (int i = 0; i < int'(v.cnt); i++) exp_dma.push_back({v.priv, mem_word(base + 26'(4 * i))});
    for (int j = 0; j < (int'(v.cnt) + 15) / 16; j++) exp_req.push_back(base + 26'(64 * j));
    dma_seen = 0; req_seen = 0; done_seen = 0; blocked = 1'b0;
    dma_addr = v.addr; dma_count = v.cnt; dma_privaledge = v.priv; dma_start = 1'b1;
    blit_fifo_slots_free = (v.slots_mode == 2) ? 10'd4 : 10'd512;
    step();
    dma_start = 1'b0;
    if (v.cnt == 16'd0) begin
      check("zero_done", 64'(dma_done), 64'd1);
      check("zero_busy", 64'(dma_busy), 64'd0);
    end
    fired = 1'b0; abort_cyc = -1; after = -1;
    for (int cyc = 1; cyc < 3000 && after < 6; cyc++) begin
      if (v.cpu_n > 0) cpu_blit_valid = (cyc >= 20 && cyc < 20 + v.cpu_n);
      else if (v.cpu_n < 0) cpu_blit_valid = ($urandom_range(0, 7) == 0);
      else cpu_blit_valid = 1'b0;
      cpu_blit_command = $urandom;
      cpu_blit_privaledge = 1'($urandom_range(0, 1));
      case (v.slots_mode)
        1: blit_fifo_slots_free = 10'($urandom_range(0, 20));
        2: blit_fifo_slots_free = (cyc < 150) ? 10'd4 : 10'd100;
        default: blit_fifo_slots_free = 10'd512;
      endcase
      if (v.slots_mode == 2 && cyc == 150) begin
        check("stall_reqs", 64'(req_seen), 64'd2);
        check("stall_no_words", 64'(dma_seen), 64'd0);
      end
      dma_abort = 1'b0;
      if (!fired && v.abort_spec > 0 && cyc >= v.abort_spec && dma_busy) begin
        dma_abort = 1'b1; fired = 1'b1;
      end
      if (!fired && v.abort_spec < 0 && req_seen >= -v.abort_spec) begin
        if (abort_cyc < 0) abort_cyc = cyc + 2;
        if (cyc == abort_cyc) begin
          dma_abort = 1'b1; fired = 1'b1;
        end
      end
      step();
      if (after >= 0) after++;
      else if (done_seen > 0) after = 0;
    end
    cpu_blit_valid = 1'b0; dma_abort = 1'b0;
    check("done_count", 64'(done_seen), 64'd1);
    check("busy_end", 64'(dma_busy), 64'd0);
    check("aborted_flag", 64'(dma_aborted), 64'(fired));
    if (!fired) begin
      check("words_fwd", 64'(dma_seen), 64'(v.cnt));
      check("req_count", 64'(req_seen), 64'(v.exp_reqs));
      check("words_left", 64'(exp_dma.size()), 64'd0);
    end
  endtask

  vec_t tbl [8];
  vec_t rv;

  initial begin
    tbl[0] = '{16'd40, 26'h000_1000, 1'b1, 0, 0,  0, 3};
    tbl[1] = '{16'd0,  26'h000_2000, 1'b0, 0, 0,  0, 0};
    tbl[2] = '{16'd40, 26'h000_4000, 1'b0, 0, 10, 0, 3};
    tbl[3] = '{16'd40, 26'h000_8000, 1'b1, 2, 0,  0, 3};
    tbl[4] = '{16'd40, 26'h000_C000, 1'b1, 0, 0, -2, 0};
    tbl[5] = '{16'd16, 26'h001_0000, 1'b0, 0, 0,  0, 1};
    tbl[6] = '{16'd17, 26'h3FF_FFC7, 1'b1, 1, -1, 0, 2};
    tbl[7] = '{16'd1,  26'h000_0100, 1'b1, 0, 0,  0, 1};

    hold_ready = 1'b0; in_burst = 1'b0; ready_drv = 1'b0; req_prev = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    check("reset_outs", {hwregs_blit_valid, hwregs_blit_command, hwregs_blit_privaledge,
                         sdram_request, sdram_address, dma_busy, dma_done, dma_aborted}, 64'd0);
    reset = 1'b0;
    step();

    for (int t = 0; t < 8; t++) run_list(tbl[t]);

    // Reset while a burst request is outstanding.
    hold_ready = 1'b1;
    dma_addr = 26'h002_0000; dma_count = 16'd32; dma_privaledge = 1'b1; dma_start = 1'b1;
    blit_fifo_slots_free = 10'd512;
    step();
    dma_start = 1'b0;
    for (int i = 0; i < 20 && !sdram_request; i++) step();
    check("req_before_reset", 64'(sdram_request), 64'd1);
    reset = 1'b1;
    step();
    check("reset_mid_outs", {hwregs_blit_valid, hwregs_blit_command, hwregs_blit_privaledge,
                             sdram_request, sdram_address, dma_busy, dma_done, dma_aborted}, 64'd0);
    reset = 1'b0; hold_ready = 1'b0;
    step();
    run_list('{16'd20, 26'h003_0000, 1'b0, 0, 0, 0, 2});

    for (int r = 0; r < 10; r++) begin
      rv.cnt = 16'($urandom_range(0, 70));
      rv.addr = 26'($urandom);
      rv.priv = 1'($urandom_range(0, 1));
      rv.slots_mode = 1;
      rv.cpu_n = -1;
      rv.abort_spec = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 100)) : 0;
      rv.exp_reqs = (int'(rv.cnt) + 15) / 16;
      run_list(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
